// File: rtl/monolith_axis_pkg.sv
// monolith_axis_pkg: shared pointer type, derived widths and configuration checks for the chunk streamer
package monolith_axis_pkg;

    // Pointers carry a generous index field; only the low bits meaningful for the build are used
    localparam int PTR_IDX_W = 16;

    typedef struct packed {
        logic                 wrap;
        logic [PTR_IDX_W-1:0] idx;
    } ptr_t;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

    function automatic int nw_words(input int cs, input int cc);
        return cs * cc;
    endfunction

    function automatic int wr_ptr_w(input int cc);
        return $clog2(cc) + 1;
    endfunction

    function automatic int rd_ptr_w(input int cs, input int cc);
        return $clog2(nw_words(cs, cc)) + 1;
    endfunction

    function automatic int fill_w(input int cs, input int cc);
        return $clog2(nw_words(cs, cc) + 1) + 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit cfg_ok(input int w, input int cs, input int cc);
        return is_pow2(cs) && is_pow2(cc) && (w > 0) && (w % 8 == 0)
            && (rd_ptr_w(cs, cc) <= PTR_IDX_W + 1) && (wr_ptr_w(cc) <= PTR_IDX_W + 1);
    endfunction

    // Advance a pointer, toggling the wrap bit when the index passes its last slot
    function automatic ptr_t ptr_inc(input ptr_t p, input int last);
        ptr_t r;
        r = p;
        if (p.idx == PTR_IDX_W'(last)) begin
            r.idx  = '0;
            r.wrap = ~p.wrap;
        end else begin
            r.idx = p.idx + 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/monolith_axis_out_reg.sv
// monolith_axis_out_reg: single-stage AXI4-Stream output register with packet framing (TLAST every N chunks)
module monolith_axis_out_reg import monolith_axis_pkg::*; #(
    parameter int W   = 32,
    parameter int CS  = 16,
    parameter int PCW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           empty,
    input  logic [W-1:0]   data,
    input  logic [PCW-1:0] packet_chunks,
    input  logic           tready,
    output logic           pop,
    output logic           tvalid,
    output logic [W-1:0]   tdata,
    output logic           tlast
);

    localparam int CSW = idx_w(CS);
    localparam int LW  = PCW + CSW;

    logic [LW-1:0]  word_cnt;
    logic [LW-1:0]  len_q;
    logic [LW-1:0]  len_cur;
    logic [PCW-1:0] chunks;
    logic           at_end;

    assign pop     = !empty && (!tvalid || tready) && !flush;
    assign chunks  = (packet_chunks == '0) ? PCW'(1) : packet_chunks;
    // A fresh packet takes its length from the live input; later words use the latched copy
    assign len_cur = (word_cnt == '0) ? (LW'(chunks) << CSW) : len_q;
    assign at_end  = (word_cnt == len_cur - 1'b1);

    // Load the next word whenever the register is free or being drained; hold it during stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tvalid   <= 1'b0;
            tdata    <= '0;
            tlast    <= 1'b0;
            word_cnt <= '0;
            len_q    <= '0;
        end else if (flush) begin
            tvalid   <= 1'b0;
            tdata    <= '0;
            tlast    <= 1'b0;
            word_cnt <= '0;
            len_q    <= '0;
        end else if (pop) begin
            tvalid   <= 1'b1;
            tdata    <= data;
            tlast    <= at_end;
            word_cnt <= at_end ? '0 : word_cnt + 1'b1;
            len_q    <= len_cur;
        end else if (tready) begin
            tvalid   <= 1'b0;
            tlast    <= 1'b0;
        end
    end

endmodule

// File: rtl/monolith_axis_chunk_streamer.sv
// monolith_axis_chunk_streamer: chunk-in / word-out AXI4-Stream master buffer; MONOLITH_AXIS_PKT_CNT_EN adds pkt_count
module monolith_axis_chunk_streamer import monolith_axis_pkg::*; #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_CHUNK_SIZE      = 16,
    parameter int FIFO_CHUNK_COUNT     = 4,
    parameter int PKT_CHUNKS_W         = 8
) (
    input  logic                                              M_AXIS_ACLK,
    input  logic                                              M_AXIS_ARESETN,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]                   chunk_in [FIFO_CHUNK_SIZE],
    input  logic                                              chunk_valid,
    output logic                                              chunk_ready,
    input  logic [PKT_CHUNKS_W-1:0]                           packet_chunks,
    input  logic                                              flush,
`ifdef MONOLITH_AXIS_PKT_CNT_EN
    output logic [31:0]                                       pkt_count,
`endif
    output logic [fill_w(FIFO_CHUNK_SIZE, FIFO_CHUNK_COUNT)-1:0] fill_words,
    output logic                                              M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]                   M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]                 M_AXIS_TSTRB,
    output logic                                              M_AXIS_TLAST,
    input  logic                                              M_AXIS_TREADY
);

    localparam int W   = C_M_AXIS_TDATA_WIDTH;
    localparam int CS  = FIFO_CHUNK_SIZE;
    localparam int CC  = FIFO_CHUNK_COUNT;
    localparam int NW  = nw_words(CS, CC);
    localparam int CSW = idx_w(CS);
    localparam int CW  = idx_w(CC);
    localparam int AW  = idx_w(NW);
    localparam int FW  = fill_w(CS, CC);

    if (!cfg_ok(W, CS, CC)) begin : g_bad_cfg
        $error("monolith_axis_chunk_streamer: sizes must be powers of two >= 2 and width a multiple of 8");
    end

    logic [W-1:0] mem [CC][CS];
    ptr_t         wr;
    ptr_t         rd;
    logic         full;
    logic         empty;
    logic         accept;
    logic         pop;
    logic         beat;

    // The read pointer counts words, so its chunk index is the word index without the in-chunk bits
    assign full         = (wr.wrap != rd.wrap) && (wr.idx == (rd.idx >> CSW));
    assign empty        = (wr.wrap == rd.wrap) && (rd.idx == (wr.idx << CSW));
    assign chunk_ready  = !full && !flush;
    assign accept       = chunk_valid && chunk_ready;
    assign beat         = M_AXIS_TVALID && M_AXIS_TREADY;
    assign M_AXIS_TSTRB = '1;

    // Whole chunk lands in its slot in one cycle
    always_ff @(posedge M_AXIS_ACLK) begin
        if (accept) mem[wr.idx[CW-1:0]] <= chunk_in;
    end

    // Pointers and occupancy; flush overrides any simultaneous write or drain
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            wr         <= '0;
            rd         <= '0;
            fill_words <= '0;
        end else if (flush) begin
            wr         <= '0;
            rd         <= '0;
            fill_words <= '0;
        end else begin
            if (accept) wr <= ptr_inc(wr, CC - 1);
            if (pop) rd <= ptr_inc(rd, NW - 1);
            fill_words <= fill_words + (accept ? FW'(CS) : '0) - FW'(beat);
        end
    end

`ifdef MONOLITH_AXIS_PKT_CNT_EN
    // Completed packets, counted on the handshake of each TLAST beat
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) pkt_count <= '0;
        else if (flush) pkt_count <= '0;
        else if (beat && M_AXIS_TLAST) pkt_count <= pkt_count + 1'b1;
    end
`endif

    monolith_axis_out_reg #(
        .W   (W),
        .CS  (CS),
        .PCW (PKT_CHUNKS_W)
    ) u_out (
        .clk           (M_AXIS_ACLK),
        .rst_n         (M_AXIS_ARESETN),
        .flush         (flush),
        .empty         (empty),
        .data          (mem[rd.idx[AW-1:CSW]][rd.idx[CSW-1:0]]),
        .packet_chunks (packet_chunks),
        .tready        (M_AXIS_TREADY),
        .pop           (pop),
        .tvalid        (M_AXIS_TVALID),
        .tdata         (M_AXIS_TDATA),
        .tlast         (M_AXIS_TLAST)
    );

endmodule

// File: tb/tb_monolith_axis_chunk_streamer.sv
// tb_monolith_axis_chunk_streamer: directed/random bench with a word-queue reference model of the chunk streamer
module tb_monolith_axis_chunk_streamer;

    localparam int W   = 32;
    localparam int CS  = 16;
    localparam int CC  = 4;
    localparam int PCW = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   chunk [CS];
    logic           chunk_valid = 1'b0;
    logic           chunk_ready;
    logic [PCW-1:0] packet_chunks = 8'd1;
    logic           flush = 1'b0;
    logic [7:0]     fill_words;
    logic           tvalid;
    logic [W-1:0]   tdata;
    logic [W/8-1:0] tstrb;
    logic           tlast;
    logic           tready = 1'b0;
`ifdef MONOLITH_AXIS_PKT_CNT_EN
    logic [31:0]    pkt_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: expected word stream, occupancy, position in packet, packet length in words
    logic [W-1:0] exp_q [$];
    int fill_m = 0;
    int pos = 0;
    int plen = 16;
    int pkts_m = 0;
    int beats = 0;
    bit pend = 0;
    bit last_acc = 0;
    bit last_beat = 0;
    bit rnd_rdy = 0;

    monolith_axis_chunk_streamer #(
        .C_M_AXIS_TDATA_WIDTH (W),
        .FIFO_CHUNK_SIZE      (CS),
        .FIFO_CHUNK_COUNT     (CC),
        .PKT_CHUNKS_W         (PCW)
    ) dut (
        .M_AXIS_ACLK    (clk),
        .M_AXIS_ARESETN (rst_n),
        .chunk_in       (chunk),
        .chunk_valid    (chunk_valid),
        .chunk_ready    (chunk_ready),
        .packet_chunks  (packet_chunks),
        .flush          (flush),
`ifdef MONOLITH_AXIS_PKT_CNT_EN
        .pkt_count      (pkt_count),
`endif
        .fill_words     (fill_words),
        .M_AXIS_TVALID  (tvalid),
        .M_AXIS_TDATA   (tdata),
        .M_AXIS_TSTRB   (tstrb),
        .M_AXIS_TLAST   (tlast),
        .M_AXIS_TREADY  (tready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample mid-cycle, compare with the model, advance the model, then pass the edge
    task automatic cycle();
        if (rnd_rdy) tready = 1'($urandom_range(0, 1));
        #2;
        last_acc  = chunk_valid && chunk_ready;
        last_beat = tvalid && tready && !flush;
        check("fill_words", fill_words, fill_m);
        if (pend) check("tvalid_held", tvalid, 1'b1);
        if (tvalid) begin
            if (exp_q.size() == 0) check("spurious_tvalid", tvalid, 1'b0);
            else begin
                check("tdata", tdata, exp_q[0]);
                check("tlast", tlast, pos == plen - 1);
            end
        end
        if (flush) begin
            exp_q.delete();
            fill_m = 0;
            pos = 0;
            pkts_m = 0;
        end else begin
            if (last_beat && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                beats++;
                if (pos == plen - 1) begin
                    pos = 0;
                    pkts_m++;
                end else pos++;
            end
            if (last_acc) foreach (chunk[i]) exp_q.push_back(chunk[i]);
            fill_m += (last_acc ? CS : 0) - (last_beat ? 1 : 0);
        end
        pend = tvalid && !tready && !flush;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit seq);
        foreach (chunk[i]) chunk[i] = seq ? W'(i) : $urandom;
        chunk_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            cycle();
            if (last_acc) break;
        end
        check("send_accepted", last_acc, 1'b1);
        chunk_valid = 1'b0;
    endtask

    task automatic wait_beats(input int target);
        for (int n = 0; n < 500 && beats < target; n++) cycle();
        check("beats_reached", beats >= target, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tvalid) && n < 2000) begin
            cycle();
            n++;
        end
        check("drain_done", exp_q.size(), 0);
    endtask

    initial begin
        int b0;
        foreach (chunk[i]) chunk[i] = '0;
        #1;
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_tlast", tlast, 1'b0);
        check("rst_tdata", tdata, 0);
        check("rst_fill", fill_words, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_ready", chunk_ready, 1'b1);
        check("tstrb", tstrb, 4'hF);
`ifdef MONOLITH_AXIS_PKT_CNT_EN
        check("rst_pkt_count", pkt_count, 0);
`endif

        // Single chunk 0..F, one chunk per packet, sink always ready
        tready = 1'b1;
        send(1'b1);
        check("lat_edge_k", tvalid, 1'b0);
        cycle();
        check("lat_edge_k1_tvalid", tvalid, 1'b1);
        check("lat_edge_k1_tdata", tdata, 0);
        b0 = beats;
        repeat (16) cycle();
        check("t1_consecutive_beats", beats - b0, 16);
        cycle();
        check("t1_fill_zero", fill_words, 0);

        // Fill every slot with the sink stalled, then release it
        tready = 1'b0;
        repeat (4) send(1'b0);
        check("full_ready", chunk_ready, 1'b0);
        check("full_fill", fill_words, 64);
        tready = 1'b1;
        b0 = beats;
        for (int n = 0; n < 100 && beats - b0 < 14; n++) cycle();
        check("ready_low_b14", chunk_ready, 1'b0);
        cycle();
        check("beat15_done", beats - b0, 15);
        check("ready_after_slot_free", chunk_ready, 1'b1);
        drain();

        // Three-chunk packets with random backpressure
        packet_chunks = 8'd3;
        plen = 48;
        rnd_rdy = 1'b1;
        repeat (3) send(1'b0);
        drain();
        rnd_rdy = 1'b0;

        // Length change mid-packet is ignored until the next packet
        packet_chunks = 8'd2;
        plen = 32;
        tready = 1'b1;
        b0 = beats;
        send(1'b0);
        send(1'b0);
        wait_beats(b0 + 5);
        packet_chunks = 8'd1;
        drain();
        plen = 16;

        // Flush mid-packet together with a chunk write
        b0 = beats;
        send(1'b0);
        send(1'b0);
        wait_beats(b0 + 5);
        foreach (chunk[i]) chunk[i] = $urandom;
        flush = 1'b1;
        chunk_valid = 1'b1;
        #1;
        check("flush_ready", chunk_ready, 1'b0);
        cycle();
        flush = 1'b0;
        chunk_valid = 1'b0;
        check("flush_tvalid", tvalid, 1'b0);
        check("flush_fill", fill_words, 0);
`ifdef MONOLITH_AXIS_PKT_CNT_EN
        check("flush_pkt_count", pkt_count, 0);
`endif
        repeat (5) cycle();

        // Five single-chunk packets under random backpressure
        rnd_rdy = 1'b1;
        repeat (5) send(1'b0);
        drain();
        rnd_rdy = 1'b0;
`ifdef MONOLITH_AXIS_PKT_CNT_EN
        check("pkt_count_5", pkt_count, pkts_m);
`endif

        // Asynchronous reset in the middle of a packet
        tready = 1'b1;
        b0 = beats;
        send(1'b0);
        wait_beats(b0 + 6);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tvalid", tvalid, 1'b0);
        check("arst_tlast", tlast, 1'b0);
        check("arst_tdata", tdata, 0);
        check("arst_fill", fill_words, 0);
        check("arst_ready", chunk_ready, 1'b1);
`ifdef MONOLITH_AXIS_PKT_CNT_EN
        check("arst_pkt_count", pkt_count, 0);
`endif
        exp_q.delete();
        fill_m = 0;
        pos = 0;
        pkts_m = 0;
        pend = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
